// File: rtl/branch_redirect_ctrl_pkg.sv
// branch_redirect_ctrl_pkg
//   Shared types for the front-end redirect controller and its prediction queue.
//   - brc_state_e  : controller states (NORMAL, single-cycle FLUSH)
//   - pred_entry_t : one unresolved prediction (predicted next PC + fall-through PC)
//   - pc_plus4     : sequential PC helper, wraps modulo 2^32
package branch_redirect_ctrl_pkg;

  typedef enum logic {
    BRC_NORMAL = 1'b0,
    BRC_FLUSH  = 1'b1
  } brc_state_e;

  typedef struct packed {
    logic [31:0] pred_next;
    logic [31:0] fall;
  } pred_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_pred_queue.sv
// pred_queue
//   DEPTH-entry circular FIFO of unresolved predictions (64-bit entries).
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     push, push_data   : enqueue an entry (caller guarantees not full)
//     pop               : dequeue the head (caller guarantees not empty)
//     clear             : drop every entry; wins over push/pop
//     head              : current oldest entry (valid when !empty)
//     full, empty       : occupancy flags, derived from the registered count
module pred_queue
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  pred_entry_t push_data,
  input  logic        pop,
  input  logic        clear,
  output pred_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  pred_entry_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Storage carries no reset: entries are only read while count says they are live.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
//   Turns decode-stage predictions into fetch redirects, tracks predictions that
//   still need execute resolution, and raises flush + corrected PC on mispredict.
//   Ports:
//     clk, rst                         : clock, synchronous active-high reset
//     dec_valid/pc/taken/target        : prediction from target_gen
//     dec_needs_res                    : BR/JALR (queued); 0 for JAL
//     dec_ready                        : decode handover allowed (registered state only)
//     ex_valid/taken/target            : resolution of the oldest queued prediction
//     redirect_valid, redirect_pc      : registered one-cycle fetch redirect
//     flush                            : registered one-cycle kill of younger work
//     mispred_cnt                      : saturating mispredict counter
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [31:0]      dec_pc,
  input  logic             dec_taken,
  input  logic [31:0]      dec_target,
  input  logic             dec_needs_res,
  output logic             dec_ready,
  input  logic             ex_valid,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] mispred_cnt
);

  brc_state_e  state_q;
  brc_state_e  state_d;
  pred_entry_t head;
  pred_entry_t push_entry;
  logic        q_full;
  logic        q_empty;
  logic        in_normal;
  logic        accept;
  logic        push;
  logic        pop;
  logic        mispredict;
  logic [31:0] correct_pc;

  assign in_normal = (state_q == BRC_NORMAL);

  // Depends only on registered state so ex_valid never reaches dec_ready.
  assign dec_ready = in_normal && !q_full;
  assign accept    = dec_valid && dec_ready;

  assign pop        = ex_valid && !q_empty && in_normal;
  assign correct_pc = ex_taken ? ex_target : head.fall;
  assign mispredict = pop && (correct_pc != head.pred_next);

  // A same-cycle mispredict marks the decode instruction as wrong-path.
  assign push = accept && dec_needs_res && !mispredict;

  assign push_entry.pred_next = dec_taken ? dec_target : pc_plus4(dec_pc);
  assign push_entry.fall      = pc_plus4(dec_pc);

  pred_queue #(
    .DEPTH(DEPTH)
  ) u_pred_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .clear    (mispredict),
    .head     (head),
    .full     (q_full),
    .empty    (q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BRC_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // FLUSH is a single bubble cycle; nothing from decode or execute is taken in it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BRC_NORMAL: if (mispredict) state_d = BRC_FLUSH;
      BRC_FLUSH:  state_d = BRC_NORMAL;
      default:    state_d = BRC_NORMAL;
    endcase
  end

  // redirect_pc holds its last value when no redirect is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      mispred_cnt    <= '0;
    end else begin
      redirect_valid <= mispredict || (accept && dec_taken);
      flush          <= mispredict;
      if (mispredict) begin
        redirect_pc <= correct_pc;
        if (!(&mispred_cnt)) mispred_cnt <= mispred_cnt + CNT_W'(1);
      end else if (accept && dec_taken) begin
        redirect_pc <= dec_target;
      end
    end
  end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequences the front-end redirect path around `target_gen`. It turns decode-stage predictions (JAL, JALR, and backward-taken/forward-not-taken branches) into fetch redirects. It tracks every prediction that still needs execute-stage resolution in an in-order queue, and issues a flush plus a corrected fetch PC when execute disagrees. It sits between decode (`target_gen` outputs), execute (branch/JALR resolution) and the fetch PC mux.

## Interface
- `DEPTH`, 4: max unresolved predictions in flight; power of two, ≥2.
- `CNT_W`, 16: width of the mispredict counter.

- `clk`  in  1  core clock.
- `rst`  in  1  synchronous, active-high reset.
- `dec_valid`  in  1  decode holds a control-flow instruction (`target_gen` `en`).
- `dec_pc`  in  32  PC of that instruction.
- `dec_taken`  in  1  `target_gen` `target_taken`.
- `dec_target`  in  32  `target_gen` `target`.
- `dec_needs_res`  in  1  instruction needs execute resolution (BR, JALR); 0 for JAL.
- `dec_ready`  out  1  decode may hand over an instruction this cycle.
- `ex_valid`  in  1  execute resolves the oldest queued prediction.
- `ex_taken`  in  1  actual direction (1 for JALR).
- `ex_target`  in  32  actual target when taken.
- `redirect_valid`  out  1  registered pulse: fetch loads `redirect_pc`.
- `redirect_pc`  out  32  registered next fetch PC.
- `flush`  out  1  registered pulse: kill all younger in-flight instructions.
- `mispred_cnt`  out  CNT_W  saturating mispredict count.

## Operation
- Queue entry: `pred_next` (= `dec_target` if `dec_taken`, else `dec_pc+4`) and `fall` (= `dec_pc+4`). All PC adds are mod 2^32.
- Accept: `dec_valid & dec_ready`. Push only if `dec_needs_res`.
- `dec_ready` = state is NORMAL and count < DEPTH. Computed only from registered state, with no combinational path from `ex_valid`.
- Accept with `dec_taken=1` → `redirect_valid=1`, `redirect_pc=dec_target` next cycle, `flush=0`.
- Resolve on `ex_valid` with a non-empty queue:
  - pop the head;
  - `correct` = `ex_taken ? ex_target : fall`;
  - mispredict if `correct != pred_next`.
- `ex_valid` with an empty queue is ignored, with no state change (protocol error; the bench asserts it never occurs).
- Mispredict:
  - clear the queue (count=0, pointers reset);
  - next cycle `flush=1`, `redirect_valid=1`, `redirect_pc=correct`;
  - `mispred_cnt` +1, saturating at all-ones.
- Priority: a mispredict in the same cycle as an accept wins. The push and the decode redirect are dropped, because that decode instruction is wrong-path.
- Push and pop in the same cycle without a mispredict: count unchanged.
- FSM:
  - NORMAL → FLUSH on mispredict.
  - FLUSH lasts exactly one cycle (`flush` high, `dec_ready=0`, `dec_*` and `ex_*` ignored), then → NORMAL.
- Reset mid-operation: the queue empties, state → NORMAL, and all outputs clear on the next edge.

## Timing
- Reset values: `redirect_valid=0`, `redirect_pc=0`, `flush=0`, `mispred_cnt=0`, `dec_ready=1`, state NORMAL, queue empty.
- Redirect/flush latency: 1 cycle after the accept or resolve edge. All three outputs are registered and high for one cycle only.
- `dec_ready` deasserts in the cycle after the DEPTH-th push and reasserts in the cycle after a pop.
- A full queue plus `ex_valid` does not allow a same-cycle push.
- Throughput: one accept and one resolve per cycle in NORMAL.

## Structure
- Add the constants `BRC_NORMAL` and `BRC_FLUSH` to `control_sel.vh`, next to the existing `TGT_GEN_*` selects.
- One sub-module: `pred_queue`, a DEPTH-entry 64-bit circular FIFO with push/pop/clear and count/full/empty flags.
- Comparison, FSM and counter logic live in the top module.

## Test plan
- Reset: hold `rst` 2 cycles → all outputs 0, `dec_ready=1`. Assert `rst` mid-stream with 3 entries queued → next cycle queue empty, `dec_ready=1`, no redirect.
- Correct taken prediction: accept BR with pc=0x3000, taken, target=0x2FFC → next cycle `redirect_pc=0x2FFC` with `flush=0`. Then `ex_valid`, taken, 0x2FFC → no redirect, `mispred_cnt=0`.
- Not-taken mispredict: accept BR with pc=0x3000, not taken (no redirect). Resolve taken to 0x3040 → next cycle `flush=1`, `redirect_pc=0x3040`, `mispred_cnt=1`. `dec_ready=0` for that one cycle, then 1.
- Full queue: 4 BR accepts → `dec_ready=0`. A fifth `dec_valid` is not accepted. One resolve → `dec_ready=1` next cycle.
- Simultaneous events: JALR queued with predicted 0x2020, actual 0x5000, resolved in the same cycle as accepting JAL target 0x100C → redirect 0x5000 only, queue empty.
- Wrap-around:
  - JAL (`dec_needs_res=0`) at 0xFFFFFFFC, target 0x4 → redirect 0x4, count unchanged.
  - BR at 0xFFFFFFFC, not taken, resolved not taken → no mispredict (`pred_next=fall=0x0`).
  - Force 70000 mispredicts with `CNT_W=16` → `mispred_cnt` holds 0xFFFF.
